// File: rtl/result_commit_buffer.sv
// ---------------------------------------------------------------------------
// result_commit_buffer
//
// Reorders out-of-order execution results back into issue order before
// register-file writeback.
//   * The issue stage allocates one slot per op (I_Alloc) and receives the slot
//     number (O_Issue_No) in the same cycle the grant (O_Alloc_Ack) is given.
//   * Execution units return results tagged with that slot number
//     (I_Valid / I_Data / I_Index / I_Issue_No).
//   * The oldest slot is offered to the register file (O_WB_*) once it is
//     complete, and is retired when I_WB_Ready is high.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   I_Alloc                 slot request from the issue stage
//   O_Alloc_Ack, O_Issue_No grant and granted slot number (tail pointer)
//   O_Full, O_Empty         occupancy flags from the registered count
//   I_Valid, I_Data,
//   I_Index, I_Issue_No     result return from an execution unit
//   O_WB_Valid, O_WB_Data,
//   O_WB_Index, I_WB_Ready  in-order writeback handshake
//   O_Err                   sticky flag: completion to a free or already-done slot
// ---------------------------------------------------------------------------
module result_commit_buffer #(
  parameter int DEPTH       = 8,
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_INDEX = 8,
  parameter int WIDTH_NO    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Alloc,
  output logic                   O_Alloc_Ack,
  output logic [WIDTH_NO-1:0]    O_Issue_No,
  output logic                   O_Full,
  output logic                   O_Empty,
  input  logic                   I_Valid,
  input  logic [WIDTH_DATA-1:0]  I_Data,
  input  logic [WIDTH_INDEX-1:0] I_Index,
  input  logic [WIDTH_NO-1:0]    I_Issue_No,
  output logic                   O_WB_Valid,
  output logic [WIDTH_DATA-1:0]  O_WB_Data,
  output logic [WIDTH_INDEX-1:0] O_WB_Index,
  input  logic                   I_WB_Ready,
  output logic                   O_Err
);

  localparam logic [WIDTH_NO:0]   DEPTH_CNT = (WIDTH_NO+1)'(DEPTH);
  localparam logic [WIDTH_NO:0]   CNT_ZERO  = {(WIDTH_NO+1){1'b0}};
  localparam logic [WIDTH_NO:0]   CNT_ONE   = (WIDTH_NO+1)'(1'b1);
  localparam logic [WIDTH_NO-1:0] PTR_ZERO  = {WIDTH_NO{1'b0}};
  localparam logic [WIDTH_NO-1:0] PTR_ONE   = WIDTH_NO'(1'b1);

  // Per-slot state
  logic [DEPTH-1:0]       alloc_bits;
  logic [DEPTH-1:0]       done_bits;
  logic [WIDTH_DATA-1:0]  data_mem  [DEPTH];
  logic [WIDTH_INDEX-1:0] index_mem [DEPTH];

  // Ring pointers and occupancy
  logic [WIDTH_NO-1:0] head;
  logic [WIDTH_NO-1:0] tail;
  logic [WIDTH_NO:0]   count;
  logic [WIDTH_NO:0]   count_next;
  logic                err;

  // Decoded control
  logic full;
  logic empty;
  logic alloc_ack;
  logic wb_valid;
  logic pop;
  logic complete_ok;

  // Control decode from registered state. A completion aimed at the slot
  // being allocated this cycle sees alloc_bits still clear and is therefore
  // reported as an error; a completion aimed at the head being popped sees
  // it already done and is likewise an error, so slot updates never collide.
  always_comb begin
    full        = (count == DEPTH_CNT);
    empty       = (count == CNT_ZERO);
    alloc_ack   = I_Alloc & ~full;
    wb_valid    = alloc_bits[head] & done_bits[head];
    pop         = wb_valid & I_WB_Ready;
    complete_ok = I_Valid & alloc_bits[I_Issue_No] & ~done_bits[I_Issue_No];
  end

  // Occupancy update: simultaneous alloc and pop cancel out.
  always_comb begin
    count_next = count;
    case ({alloc_ack, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Slot, pointer and error state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alloc_bits <= {DEPTH{1'b0}};
      done_bits  <= {DEPTH{1'b0}};
      head       <= PTR_ZERO;
      tail       <= PTR_ZERO;
      count      <= CNT_ZERO;
      err        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i]  <= {WIDTH_DATA{1'b0}};
        index_mem[i] <= {WIDTH_INDEX{1'b0}};
      end
    end else begin
      if (pop) begin
        alloc_bits[head] <= 1'b0;
        done_bits[head]  <= 1'b0;
        head             <= head + PTR_ONE;
      end
      if (alloc_ack) begin
        alloc_bits[tail] <= 1'b1;
        done_bits[tail]  <= 1'b0;
        tail             <= tail + PTR_ONE;
      end
      if (complete_ok) begin
        done_bits[I_Issue_No] <= 1'b1;
        data_mem[I_Issue_No]  <= I_Data;
        index_mem[I_Issue_No] <= I_Index;
      end
      if (I_Valid && !complete_ok) begin
        err <= 1'b1;
      end
      count <= count_next;
    end
  end

  assign O_Alloc_Ack = alloc_ack;
  assign O_Issue_No  = tail;
  assign O_Full      = full;
  assign O_Empty     = empty;
  assign O_WB_Valid  = wb_valid;
  assign O_WB_Data   = wb_valid ? data_mem[head]  : {WIDTH_DATA{1'b0}};
  assign O_WB_Index  = wb_valid ? index_mem[head] : {WIDTH_INDEX{1'b0}};
  assign O_Err       = err;

endmodule

// File: tb/tb_result_commit_buffer.sv
// ---------------------------------------------------------------------------
// tb_result_commit_buffer
//
// Directed bench for result_commit_buffer: a table of per-cycle vectors for
// the basic in-order commit sequence, plus hand-written sequences for full /
// wrap, backpressure, protocol errors, mid-operation reset and concurrency.
// Inputs are driven 1 time unit after the rising edge and outputs checked
// 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_result_commit_buffer;

  logic        clock;
  logic        reset;
  logic        I_Alloc;
  logic        O_Alloc_Ack;
  logic [2:0]  O_Issue_No;
  logic        O_Full;
  logic        O_Empty;
  logic        I_Valid;
  logic [31:0] I_Data;
  logic [7:0]  I_Index;
  logic [2:0]  I_Issue_No;
  logic        O_WB_Valid;
  logic [31:0] O_WB_Data;
  logic [7:0]  O_WB_Index;
  logic        I_WB_Ready;
  logic        O_Err;

  int total;
  int bad;

  result_commit_buffer dut (
    .clock      (clock),
    .reset      (reset),
    .I_Alloc    (I_Alloc),
    .O_Alloc_Ack(O_Alloc_Ack),
    .O_Issue_No (O_Issue_No),
    .O_Full     (O_Full),
    .O_Empty    (O_Empty),
    .I_Valid    (I_Valid),
    .I_Data     (I_Data),
    .I_Index    (I_Index),
    .I_Issue_No (I_Issue_No),
    .O_WB_Valid (O_WB_Valid),
    .O_WB_Data  (O_WB_Data),
    .O_WB_Index (O_WB_Index),
    .I_WB_Ready (I_WB_Ready),
    .O_Err      (O_Err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        alloc;
    logic        valid;
    logic [31:0] data;
    logic [7:0]  index;
    logic [2:0]  ino;
    logic        ready;
    logic        e_ack;
    logic [2:0]  e_issue;
    logic        e_full;
    logic        e_empty;
    logic        e_wbv;
    logic [31:0] e_wbd;
    logic [7:0]  e_wbi;
    logic        e_err;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic alloc, input logic valid, input logic [31:0] data,
                       input logic [7:0] index, input logic [2:0] ino, input logic ready);
    I_Alloc    = alloc;
    I_Valid    = valid;
    I_Data     = data;
    I_Index    = index;
    I_Issue_No = ino;
    I_WB_Ready = ready;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle();

    // -------------------------------------------------------------- reset
    do_reset();
    chk("rst_wbv",   {63'd0, O_WB_Valid},  64'd0);
    chk("rst_wbd",   {32'd0, O_WB_Data},   64'd0);
    chk("rst_wbi",   {56'd0, O_WB_Index},  64'd0);
    chk("rst_issue", {61'd0, O_Issue_No},  64'd0);
    chk("rst_full",  {63'd0, O_Full},      64'd0);
    chk("rst_empty", {63'd0, O_Empty},     64'd1);
    chk("rst_ack",   {63'd0, O_Alloc_Ack}, 64'd0);
    chk("rst_err",   {63'd0, O_Err},       64'd0);

    // -------------------------------------------------- T1 in-order commit
    //          alloc valid data    idx   ino   rdy  ack issue full empty wbv wbd     wbi   err
    tbl[0] = '{1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'hC, 8'h2, 3'd2, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'hA, 8'h0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'hB, 8'h1, 3'd1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 32'hA, 8'h0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 32'hB, 8'h1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 32'hC, 8'h2, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].alloc, tbl[i].valid, tbl[i].data, tbl[i].index, tbl[i].ino, tbl[i].ready);
      chk($sformatf("t1_ack[%0d]", i),   {63'd0, O_Alloc_Ack}, {63'd0, tbl[i].e_ack});
      chk($sformatf("t1_issue[%0d]", i), {61'd0, O_Issue_No},  {61'd0, tbl[i].e_issue});
      chk($sformatf("t1_full[%0d]", i),  {63'd0, O_Full},      {63'd0, tbl[i].e_full});
      chk($sformatf("t1_empty[%0d]", i), {63'd0, O_Empty},     {63'd0, tbl[i].e_empty});
      chk($sformatf("t1_wbv[%0d]", i),   {63'd0, O_WB_Valid},  {63'd0, tbl[i].e_wbv});
      chk($sformatf("t1_wbd[%0d]", i),   {32'd0, O_WB_Data},   {32'd0, tbl[i].e_wbd});
      chk($sformatf("t1_wbi[%0d]", i),   {56'd0, O_WB_Index},  {56'd0, tbl[i].e_wbi});
      chk($sformatf("t1_err[%0d]", i),   {63'd0, O_Err},       {63'd0, tbl[i].e_err});
      step();
    end

    // ------------------------------------------------------ T2 full / wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
      chk($sformatf("t2_ack[%0d]", i),   {63'd0, O_Alloc_Ack}, 64'd1);
      chk($sformatf("t2_issue[%0d]", i), {61'd0, O_Issue_No},  64'(i));
      step();
    end
    drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
    chk("t2_full",      {63'd0, O_Full},      64'd1);
    chk("t2_ack9",      {63'd0, O_Alloc_Ack}, 64'd0);
    step();
    drive(1'b0, 1'b1, 32'h1234, 8'h5, 3'd0, 1'b0);
    step();
    // Pop of slot 0 and alloc in the same cycle: alloc still refused.
    drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1);
    chk("t2_popv",      {63'd0, O_WB_Valid},  64'd1);
    chk("t2_popd",      {32'd0, O_WB_Data},   64'h1234);
    chk("t2_ack_pop",   {63'd0, O_Alloc_Ack}, 64'd0);
    step();
    drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
    chk("t2_notfull",   {63'd0, O_Full},      64'd0);
    chk("t2_ack_wrap",  {63'd0, O_Alloc_Ack}, 64'd1);
    chk("t2_issue_wrap",{61'd0, O_Issue_No},  64'd0);
    step();
    idle();
    chk("t2_refull",    {63'd0, O_Full},      64'd1);

    // ---------------------------------------------------- T3 backpressure
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0); step();
    drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0); step();
    drive(1'b0, 1'b1, 32'h55, 8'h11, 3'd0, 1'b0); step();
    drive(1'b0, 1'b1, 32'h66, 8'h22, 3'd1, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      idle();
      chk($sformatf("t3_hold_v[%0d]", i), {63'd0, O_WB_Valid}, 64'd1);
      chk($sformatf("t3_hold_d[%0d]", i), {32'd0, O_WB_Data},  64'h55);
      chk($sformatf("t3_hold_i[%0d]", i), {56'd0, O_WB_Index}, 64'h11);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1);
    chk("t3_pop_d",     {32'd0, O_WB_Data},   64'h55);
    step();
    idle();
    chk("t3_one_pop_v", {63'd0, O_WB_Valid},  64'd1);
    chk("t3_one_pop_d", {32'd0, O_WB_Data},   64'h66);
    chk("t3_one_pop_i", {56'd0, O_WB_Index},  64'h22);
    chk("t3_not_empty", {63'd0, O_Empty},     64'd0);
    step();
    drive(1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1); step();
    idle();
    chk("t3_empty",     {63'd0, O_Empty},     64'd1);

    // ------------------------------------------------------- T4 errors
    do_reset();
    drive(1'b0, 1'b1, 32'hDEAD, 8'h7, 3'd5, 1'b1); step();
    idle();
    chk("t4_unalloc_err", {63'd0, O_Err},      64'd1);
    chk("t4_unalloc_wbv", {63'd0, O_WB_Valid}, 64'd0);
    chk("t4_unalloc_emp", {63'd0, O_Empty},    64'd1);
    do_reset();
    drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0); step();
    drive(1'b0, 1'b1, 32'h77, 8'h3, 3'd0, 1'b0); step();
    idle();
    chk("t4_first_noerr", {63'd0, O_Err},      64'd0);
    drive(1'b0, 1'b1, 32'h99, 8'h4, 3'd0, 1'b0); step();
    idle();
    chk("t4_dup_err",     {63'd0, O_Err},      64'd1);
    chk("t4_dup_wbv",     {63'd0, O_WB_Valid}, 64'd1);
    chk("t4_dup_keep_d",  {32'd0, O_WB_Data},  64'h77);
    chk("t4_dup_keep_i",  {56'd0, O_WB_Index}, 64'h3);
    step();
    chk("t4_err_sticky",  {63'd0, O_Err},      64'd1);

    // ----------------------------------------------- T5 reset mid-operation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0); step();
    end
    drive(1'b0, 1'b1, 32'hE0, 8'h10, 3'd0, 1'b0); step();
    drive(1'b0, 1'b1, 32'hE2, 8'h12, 3'd2, 1'b0); step();
    drive(1'b0, 1'b1, 32'h0, 8'h0, 3'd6, 1'b0); step();
    idle();
    chk("t5_pre_wbv",  {63'd0, O_WB_Valid}, 64'd1);
    chk("t5_pre_err",  {63'd0, O_Err},      64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_empty", {63'd0, O_Empty},    64'd1);
    chk("t5_async_wbv",   {63'd0, O_WB_Valid}, 64'd0);
    chk("t5_async_err",   {63'd0, O_Err},      64'd0);
    chk("t5_async_issue", {61'd0, O_Issue_No}, 64'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1);
      chk($sformatf("t5_no_wb[%0d]", i), {63'd0, O_WB_Valid}, 64'd0);
      step();
    end
    drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
    chk("t5_realloc_ack",   {63'd0, O_Alloc_Ack}, 64'd1);
    chk("t5_realloc_issue", {61'd0, O_Issue_No},  64'd0);
    step();

    // ------------------------------------------------------ T6 concurrency
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0); step();
    end
    drive(1'b0, 1'b1, 32'hAA, 8'h1A, 3'd0, 1'b0); step();
    // Alloc slot 3, complete slot 1, pop slot 0 all at once.
    drive(1'b1, 1'b1, 32'hBB, 8'h1B, 3'd1, 1'b1);
    chk("t6_ack",   {63'd0, O_Alloc_Ack}, 64'd1);
    chk("t6_issue", {61'd0, O_Issue_No},  64'd3);
    chk("t6_wbd0",  {32'd0, O_WB_Data},   64'hAA);
    step();
    idle();
    chk("t6_wbv1",  {63'd0, O_WB_Valid},  64'd1);
    chk("t6_wbd1",  {32'd0, O_WB_Data},   64'hBB);
    chk("t6_wbi1",  {56'd0, O_WB_Index},  64'h1B);
    chk("t6_tail",  {61'd0, O_Issue_No},  64'd4);
    chk("t6_err",   {63'd0, O_Err},       64'd0);
    // Count must still be 3: four more allocs leave room, the fifth fills.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0);
      chk($sformatf("t6_fill_full[%0d]", i), {63'd0, O_Full}, 64'd0);
      step();
    end
    idle();
    chk("t6_full_after5", {63'd0, O_Full}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
